// File: rtl/axis_ifmaps_row_packer_pkg.sv
// ifmaps_pkg: shared sizing helpers and defaults for the ifmap row packer
package ifmaps_pkg;
  localparam int DEF_ELEM_W = 5;
  localparam int DEF_MAC_NUM = 256;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int epb(input int dw, input int ew);
    return dw / ew;
  endfunction
  function automatic int row_w(input int mac, input int ew);
    return mac * ew;
  endfunction
endpackage

// File: rtl/axis_ifmaps_row_packer_if.sv
// axis_ifmaps_row_packer_if: input beat stream and output row stream of the packer
interface axis_ifmaps_row_packer_if
  import ifmaps_pkg::*;
#(
  parameter int DW = 32,
  parameter int ROW_W = row_w(DEF_MAC_NUM, DEF_ELEM_W)
);
  logic [DW-1:0] s_axis_tdata;
  logic s_axis_tvalid;
  logic s_axis_tlast;
  logic s_axis_tready;
  logic [ROW_W-1:0] m_row_data;
  logic m_row_valid;
  logic m_row_ready;
  modport slave (
    input s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_row_ready,
    output s_axis_tready, m_row_data, m_row_valid
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_row_ready,
    input s_axis_tready, m_row_data, m_row_valid
  );
endinterface

// File: rtl/axis_ifmaps_row_packer_fifo.sv
// ifmaps_row_fifo: row FIFO with per-lane masked writes into the slot being built
module ifmaps_row_fifo
  import ifmaps_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int MAC_NUM = DEF_MAC_NUM,
  parameter int DEPTH = 4,
  localparam int ROW_W = row_w(MAC_NUM, ELEM_W),
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic [MAC_NUM-1:0] wr_mask,
  input  logic [ROW_W-1:0] wr_data,
  input  logic commit,
  input  logic pop,
  output logic [ROW_W-1:0] rd_data,
  output logic rd_valid,
  output logic [CNT_W-1:0] count,
  output logic full,
  output logic empty
);
  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign rd_valid = ~empty;
  assign do_pop = pop & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(commit);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count <= count + CNT_W'(commit) - CNT_W'(do_pop);
    end
  end
  // storage is never reset: empty forces rd_data to zero and first beats clear their slot
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAC_NUM; k++)
      if (wr_mask[k]) mem[wr_ptr][k*ELEM_W +: ELEM_W] <= wr_data[k*ELEM_W +: ELEM_W];
  end
endmodule

// File: rtl/axis_ifmaps_row_packer.sv
// axis_ifmaps_row_packer: packs AXIS beats of ifmap elements into MAC-width rows
module axis_ifmaps_row_packer
  import ifmaps_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int MAC_NUM = DEF_MAC_NUM,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_W = 12,
  localparam int CNT_W = clog2(FIFO_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  axis_ifmaps_row_packer_if.slave bus,
  input  logic enable,
  input  logic soft_clear,
  input  logic [CH_W-1:0] channel_size,
  output logic [CNT_W-1:0] fifo_count,
  output logic fifo_full,
  output logic fifo_empty
);
  localparam int EPB = epb(C_S_AXIS_TDATA_WIDTH, ELEM_W);
  localparam int ROW_W = row_w(MAC_NUM, ELEM_W);
  localparam int LW = clog2(MAC_NUM + EPB) + 1;
  localparam int CHE_W = clog2(MAC_NUM + 1);
  localparam logic [31:0] MAC_U = MAC_NUM;
  logic [LW-1:0] lane_cnt;
  logic [CHE_W-1:0] ch_eff, ch_new, ch_cur;
  logic [31:0] ch_in;
  logic first, accept, done;
  logic [MAC_NUM-1:0] hit, wr_mask;
  logic [ROW_W-1:0] wr_data;
  assign bus.s_axis_tready = enable & ~fifo_full & ~soft_clear & ~rst;
  assign accept = bus.s_axis_tvalid & bus.s_axis_tready;
  assign first = lane_cnt == '0;
  assign ch_in = 32'(channel_size);
  assign ch_new = (ch_in == 0 || ch_in > MAC_U) ? CHE_W'(MAC_NUM) : CHE_W'(channel_size);
  assign ch_cur = first ? ch_new : ch_eff;
  assign done = accept & ((lane_cnt + LW'(EPB) >= LW'(ch_cur)) | bus.s_axis_tlast);
  assign wr_mask = accept ? (first ? '1 : hit) : '0;
  // lane_cnt only steps by EPB, so lane k is always fed by element k % EPB
  for (genvar k = 0; k < MAC_NUM; k++) begin : g_lane
    assign hit[k] = lane_cnt == LW'((k / EPB) * EPB) && LW'(k) < LW'(ch_cur);
    assign wr_data[k*ELEM_W +: ELEM_W] = hit[k] ? bus.s_axis_tdata[(k % EPB)*ELEM_W +: ELEM_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst || soft_clear) begin
      lane_cnt <= '0;
      ch_eff <= '0;
    end else if (accept) begin
      lane_cnt <= done ? '0 : lane_cnt + LW'(EPB);
      if (first) ch_eff <= ch_new;
    end
  end
  ifmaps_row_fifo #(
    .ELEM_W(ELEM_W),
    .MAC_NUM(MAC_NUM),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(soft_clear),
    .wr_mask(wr_mask),
    .wr_data(wr_data),
    .commit(done),
    .pop(bus.m_row_ready),
    .rd_data(bus.m_row_data),
    .rd_valid(bus.m_row_valid),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_axis_ifmaps_row_packer.sv
// tb_axis_ifmaps_row_packer: random beats against an element-level row model with a scoreboard
module tb_axis_ifmaps_row_packer;
  localparam int DW = 32, EW = 5, MAC = 256, DEPTH = 4, CH_W = 12, CNT_W = 3;
  localparam int EPB = DW / EW, ROW_W = MAC * EW;
  logic clk = 0, rst = 1, enable = 0, soft_clear = 0;
  logic [CH_W-1:0] channel_size = 0;
  logic [CNT_W-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  axis_ifmaps_row_packer_if #(.DW(DW), .ROW_W(ROW_W)) bus ();
  axis_ifmaps_row_packer #(
    .C_S_AXIS_TDATA_WIDTH(DW), .ELEM_W(EW), .MAC_NUM(MAC), .FIFO_DEPTH(DEPTH), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .enable(enable), .soft_clear(soft_clear),
    .channel_size(channel_size), .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );
  always #5 clk = ~clk;

  logic [ROW_W-1:0] exp_q[$];
  logic [EW-1:0] lanes [MAC];
  int pos = 0, ch = MAC, n_checks = 0, n_pass = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_row(input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      for (int k = 0; k < MAC; k++)
        if (act[k*EW +: EW] !== exp[k*EW +: EW]) begin
          $display("FAIL m_row_data lane %0d: got %0d expected %0d at %0t", k, act[k*EW +: EW], exp[k*EW +: EW], $time);
          break;
        end
    end
  endtask

  // reference: elements fill lanes in arrival order; a row closes when ch lanes are spanned or tlast
  task automatic model_beat(input logic [DW-1:0] d, input logic last);
    logic [ROW_W-1:0] row;
    if (pos == 0) begin
      ch = (channel_size == 0 || channel_size > MAC) ? MAC : int'(channel_size);
      foreach (lanes[i]) lanes[i] = '0;
    end
    for (int j = 0; j < EPB; j++) if (pos + j < ch) lanes[pos + j] = d[j*EW +: EW];
    pos += EPB;
    if (pos >= ch || last) begin
      for (int k = 0; k < MAC; k++) row[k*EW +: EW] = lanes[k];
      exp_q.push_back(row);
      pos = 0;
    end
  endtask

  always @(negedge clk) begin
    bit acc;
    acc = bus.s_axis_tvalid && enable && exp_q.size() < DEPTH && !soft_clear && !rst;
    if (armed) begin
      chk("fifo_count", 32'(fifo_count), exp_q.size());
      chk("fifo_empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
      chk("fifo_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
      chk("m_row_valid", 32'(bus.m_row_valid), 32'(exp_q.size() != 0));
      chk("s_axis_tready", 32'(bus.s_axis_tready), 32'(acc || (!bus.s_axis_tvalid && enable && exp_q.size() < DEPTH && !soft_clear && !rst)));
      chk_row(bus.m_row_data, exp_q.size() != 0 ? exp_q[0] : '0);
      if (bus.m_row_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (rst || soft_clear) begin
      exp_q.delete();
      pos = 0;
      armed = 1;
    end else if (acc) model_beat(bus.s_axis_tdata, bus.s_axis_tlast);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int t;
    t = 0;
    bus.s_axis_tdata = d;
    bus.s_axis_tlast = last;
    bus.s_axis_tvalid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.s_axis_tready && t < 300);
    if (!bus.s_axis_tready) begin
      n_checks++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", t);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 0;
    bus.s_axis_tlast = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.m_row_ready = 1;
    while (!fifo_empty && t < 300) begin
      tick(1);
      t++;
    end
    chk("drain_empty", 32'(fifo_empty), 1);
    bus.m_row_ready = 0;
  endtask

  function automatic logic [DW-1:0] rnd_ch_pick();
    logic [DW-1:0] opts [10];
    opts = '{0, 1, 5, 6, 7, 13, 40, 256, 300, 0};
    opts[9] = $urandom_range(1, 256);
    return opts[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic [DW-1:0] d;
    bit stim_done;
    bus.s_axis_tdata = 0;
    bus.s_axis_tvalid = 0;
    bus.s_axis_tlast = 0;
    bus.m_row_ready = 0;
    tick(3);
    rst = 0;
    enable = 1;
    // full 256-lane row, element value = global index mod 32
    channel_size = 256;
    for (int b = 0; b < 43; b++) begin
      d = $urandom;
      for (int j = 0; j < EPB; j++) d[j*EW +: EW] = EW'((b * EPB + j) % 32);
      send(d, 0);
    end
    tick(2);
    drain();
    // short rows of all-ones elements
    channel_size = 16;
    for (int b = 0; b < 6; b++) send(32'h3FFF_FFFF, 0);
    tick(1);
    drain();
    // early termination on tlast
    channel_size = 256;
    for (int b = 0; b < 10; b++) send($urandom, b == 9);
    for (int b = 0; b < 4; b++) send($urandom, b == 3);
    tick(1);
    drain();
    // fill to full, stall, then one pop admits exactly one more row
    channel_size = 6;
    for (int b = 0; b < 4; b++) send($urandom, 0);
    tick(3);
    bus.m_row_ready = 1;
    tick(1);
    bus.m_row_ready = 0;
    send($urandom, 0);
    tick(2);
    drain();
    // random channel counts (changing mid-row), random tlast and random back-pressure
    stim_done = 0;
    fork
      begin
        for (int b = 0; b < 180; b++) begin
          channel_size = CH_W'(rnd_ch_pick());
          send($urandom, $urandom_range(0, 7) == 0);
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          bus.m_row_ready = $urandom_range(0, 1) == 1;
          tick(1);
        end
      end
    join
    drain();
    // soft_clear mid-row with two rows queued, then reset mid-row
    channel_size = 6;
    for (int b = 0; b < 2; b++) send($urandom, 0);
    channel_size = 256;
    for (int b = 0; b < 5; b++) send($urandom, 0);
    soft_clear = 1;
    tick(1);
    soft_clear = 0;
    tick(1);
    channel_size = 12;
    for (int b = 0; b < 2; b++) send($urandom, 0);
    tick(2);
    channel_size = 256;
    for (int b = 0; b < 3; b++) send($urandom, 0);
    rst = 1;
    tick(1);
    rst = 0;
    tick(1);
    channel_size = 20;
    for (int b = 0; b < 4; b++) send($urandom, 0);
    tick(2);
    drain();
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/axis_ifmaps_row_packer.md
Name: axis_ifmaps_row_packer

Overview:
Packs a stream of AXI-Stream words carrying ifmap elements into full MAC-width rows (MAC_NUM lanes x ELEM_W bits) and buffers them in a small row FIFO for the MAC array.
- Successor of the fixed 256-channel preload buffer. Adds runtime channel count, early row termination on TLAST, a true-depth full flag, ready/valid on both sides, flush, and occupancy reporting.
- Sits between the AXIS DMA input and the MAC array ifmap port.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, input beat width
ELEM_W, 5, bits per ifmap element
MAC_NUM, 256, lanes per row (max channels per row)
FIFO_DEPTH, 4, rows stored (power of two, >=2)
CH_W, 12, width of channel_size
Derived constants:
- EPB = C_S_AXIS_TDATA_WIDTH / ELEM_W (integer division; 6 at defaults), elements per beat.
- ROW_W = MAC_NUM*ELEM_W.
- CNT_W = clog2(FIFO_DEPTH+1).

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  element j in bits [j*ELEM_W +: ELEM_W], j<EPB; bits above EPB*ELEM_W ignored
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  ends current row early
s_axis_tready  out  1  beat accepted when tvalid&tready
enable  in  1  gates acceptance (replaces load strobe)
soft_clear  in  1  synchronous flush of FIFO and partial row
channel_size  in  CH_W  channels per row; 0 or >MAC_NUM treated as MAC_NUM
m_row_data  out  ROW_W  head row, lane k at [k*ELEM_W +: ELEM_W]
m_row_valid  out  1  FIFO not empty
m_row_ready  in  1  MAC pops head row when valid&ready
fifo_count  out  CNT_W  committed rows, 0..FIFO_DEPTH
fifo_full  out  1  fifo_count==FIFO_DEPTH
fifo_empty  out  1  fifo_count==0

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - wr_ptr, rd_ptr, fifo_count and lane_cnt are cleared to 0.
  - Outputs take their reset values: s_axis_tready=0, m_row_valid=0, fifo_empty=1, fifo_full=0, fifo_count=0, m_row_data=0.
  - Reset mid-row discards the partial row.
- m_row_data is forced to 0 whenever the FIFO is empty, so storage needs no reset.
- s_axis_tready = enable & ~fifo_full & ~soft_clear & ~rst. It is combinational from registered state and does not depend on tvalid.
- Lane counter lane_cnt (0..MAC_NUM-1) holds the lane index of the next element in the row being built in slot wr_ptr.
- Effective channel count ch_eff is latched from channel_size on the first beat of each row (lane_cnt==0). Changes mid-row are ignored.
- On each accepted beat:
  - Element j writes lane lane_cnt+j, only if lane_cnt+j < ch_eff.
  - Lanes >= ch_eff are never written with data.
  - On the first beat of a row, every lane of the slot not written by that beat is cleared to 0, so unused and unreached lanes read 0.
- Row completes on an accepted beat when (lane_cnt+EPB >= ch_eff) or s_axis_tlast. On completion:
  - lane_cnt returns to 0.
  - wr_ptr increments (wraps modulo FIFO_DEPTH).
  - The row is committed.
- Without completion, lane_cnt advances by EPB.
- Latency: m_row_valid is high in the cycle after the completing beat's acceptance edge. No bypass.
- Pop: m_row_valid & m_row_ready advances rd_ptr (wraps modulo FIFO_DEPTH). A pop when empty has no effect.
- fifo_count update:
  - Commit and pop in the same cycle: unchanged.
  - Commit only: +1.
  - Pop only: -1.
- Full: a full FIFO blocks new beats (tready=0), including the first beat of the next row. A partial row is always in a non-committed slot, so it is never blocked mid-row by its own slot.
- soft_clear: next cycle wr_ptr=rd_ptr=0, fifo_count=0, lane_cnt=0. It overrides concurrent commit and pop.
- Arithmetic:
  - Lane comparisons use width clog2(MAC_NUM+EPB)+1 so that lane_cnt+EPB cannot overflow.
  - ch_eff width is clog2(MAC_NUM+1).

Decomposition:
- Shared package (ifmaps_pkg): clog2 function, EPB/ROW_W derivation, default ELEM_W=5 and MAC_NUM=256.
- One sub-module, ifmaps_row_fifo: pointer and count logic with full, empty and count outputs, and per-lane masked write into the slot at wr_ptr.
- The packer top holds lane_cnt, ch_eff latch, lane mask generation and the handshake.

Test Plan:
1. channel_size=256, 43 beats, element value = global index mod 32, m_row_ready=0 -> one row committed after beat 43. Lanes 0..255 = idx mod 32. Beat-43 elements 4,5 dropped. fifo_count=1.
2. channel_size=16, 3 beats of 0x3FFFFFFF -> lanes 0..15 = 31, lanes 16..255 = 0. Row commits on beat 3. Second row starts at lane 0.
3. channel_size=256, tlast on beat 10 -> row commits with lanes 0..59 data, 60..255 zero. Next beat lands in lane 0 of the next slot.
4. channel_size=6, m_row_ready=0, continuous tvalid -> 4 rows commit in 4 cycles. fifo_full=1, tready=0 from cycle 5. Then one pop -> tready=1 next cycle, count back to 4 after the next beat.
5. fifo_count=3, commit and pop in same cycle -> count stays 3. Head advances to the next row in order, and data matches the write order across pointer wrap (at least 10 rows).
6. soft_clear mid-row (lane_cnt=30, count=2), then rst mid-row -> count=0, empty=1, m_row_data=0. The next row starts at lane 0 with no stale lanes.
